// File: rtl/mmcm_reset_sequencer.sv
// rtl/mmcm_reset_sequencer.sv - MMCM reset pulse, lock wait with timeout/retries, lock filter, core reset release
module mmcm_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       ext_rst_n,
  input  logic       mmcm_locked,
  input  logic       soft_rst_req,
  output logic       mmcm_rst,
  output logic       core_rst_n,
  output logic       seq_fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  logic          lock_meta;
  logic          lock_s;
  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [CW-1:0] cnt;
  logic [3:0]    retry_cnt;
  logic [3:0]    next_retry;
  logic          count_loss;

  always_comb begin
    next_state = state;
    next_retry = retry_cnt;
    count_loss = 1'b0;
    case (state)
      S_RESET: begin
        if (cnt == RST_LAST) next_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          next_state = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          next_retry = retry_cnt + 4'd1;
          next_state = (next_retry == RETRY_LIMIT) ? S_FAULT : S_RESET;
        end
      end
      S_STABLE: begin
        // Any dropout sends us back to wait with a fresh timeout but the same retry budget.
        if (!lock_s) begin
          next_state = S_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          next_state = S_RUN;
          next_retry = 4'd0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          next_state = S_RESET;
          count_loss = 1'b1;
        end else if (soft_rst_req) begin
          next_state = S_RESET;
        end
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_RESET;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!ext_rst_n) begin
      lock_meta       <= 1'b0;
      lock_s          <= 1'b0;
      state           <= S_RESET;
      cnt             <= '0;
      retry_cnt       <= 4'd0;
      mmcm_rst        <= 1'b1;
      core_rst_n      <= 1'b0;
      seq_fault       <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      lock_meta  <= mmcm_locked;
      lock_s     <= lock_meta;
      state      <= next_state;
      retry_cnt  <= next_retry;
      if (next_state != state) begin
        cnt <= '0;
      end else if (state != S_RUN && state != S_FAULT) begin
        cnt <= cnt + CW'(1);
      end
      mmcm_rst   <= (next_state == S_RESET) || (next_state == S_FAULT);
      core_rst_n <= (next_state == S_RUN);
      seq_fault  <= seq_fault | (next_state == S_FAULT);
      if (count_loss && lock_loss_count != 8'hFF) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// tb/tb_mmcm_reset_sequencer.sv - directed and randomized checks against an elapsed-time reference model
module tb_mmcm_reset_sequencer;

  localparam int RSTC = 4;
  localparam int TOUT = 20;
  localparam int STBC = 8;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       ext_rst_n = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       mmcm_rst;
  logic       core_rst_n;
  logic       seq_fault;
  logic [7:0] lock_loss_count;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  // Reference model: phase numbers are the published state_o values.
  int m_phase = 0;
  int m_time = 0;
  int m_tries = 0;
  int m_losses = 0;
  bit m_hist1 = 0;
  bit m_hist2 = 0;

  int cyc = 0;
  int t_stable = 0;
  int t_run = 0;
  logic [2:0] seq[$];
  logic [2:0] last_state = 3'd0;
  logic last_core = 1'b0;

  mmcm_reset_sequencer #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TOUT), .STABLE_CYCLES(STBC), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .ext_rst_n(ext_rst_n), .mmcm_locked(mmcm_locked),
    .soft_rst_req(soft_rst_req), .mmcm_rst(mmcm_rst), .core_rst_n(core_rst_n),
    .seq_fault(seq_fault), .lock_loss_count(lock_loss_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rn, input bit lk, input bit sr);
    int nxt;
    bit seen;
    if (!rn) begin
      m_phase = 0; m_time = 0; m_tries = 0; m_losses = 0; m_hist1 = 0; m_hist2 = 0;
      return;
    end
    seen = m_hist2;
    nxt = m_phase;
    if (m_phase == 0 && m_time + 1 == RSTC) nxt = 1;
    if (m_phase == 1) begin
      if (seen) nxt = 2;
      else if (m_time + 1 == TOUT) begin
        m_tries++;
        nxt = (m_tries == MAXR) ? 4 : 0;
      end
    end
    if (m_phase == 2) begin
      if (!seen) nxt = 1;
      else if (m_time + 1 == STBC) begin nxt = 3; m_tries = 0; end
    end
    if (m_phase == 3) begin
      if (!seen) begin nxt = 0; m_losses = (m_losses < 255) ? m_losses + 1 : 255; end
      else if (sr) nxt = 0;
    end
    m_time = (nxt != m_phase) ? 0 : m_time + 1;
    m_phase = nxt;
    m_hist2 = m_hist1;
    m_hist1 = lk;
  endtask

  task automatic tick(input bit rn, input bit lk, input bit sr);
    @(negedge clk);
    ext_rst_n = rn; mmcm_locked = lk; soft_rst_req = sr;
    @(posedge clk);
    model(rn, lk, sr);
    #1;
    cyc++;
    chk("state_o", state_o, m_phase);
    chk("mmcm_rst", mmcm_rst, (m_phase == 0 || m_phase == 4));
    chk("core_rst_n", core_rst_n, (m_phase == 3));
    chk("seq_fault", seq_fault, (m_phase == 4));
    chk("lock_loss_count", lock_loss_count, m_losses);
    if (state_o == 3'd2 && last_state != 3'd2) t_stable = cyc;
    if (core_rst_n && !last_core) t_run = cyc;
    if (seq.size() == 0 || seq[$] != state_o) seq.push_back(state_o);
    last_state = state_o;
    last_core = core_rst_n;
  endtask

  task automatic run_until(input logic [2:0] target, input bit lk, input int maxc, input string tag);
    for (int i = 0; i < maxc && state_o != target; i++) tick(1, lk, 0);
    chk(tag, state_o, target);
  endtask

  function automatic int pack_seq();
    int p = 0;
    foreach (seq[i]) p = (p << 3) | int'(seq[i]);
    return p;
  endfunction

  initial begin
    int n;
    int seglen;
    int segs[$];
    bit core_bad;
    bit lk;

    // Nominal bring-up
    tick(0, 0, 0); tick(0, 0, 0);
    chk("rst_state", state_o, 0);
    chk("rst_mmcm", mmcm_rst, 1);
    chk("rst_core", core_rst_n, 0);
    chk("rst_fault", seq_fault, 0);
    chk("rst_count", lock_loss_count, 0);
    seq.delete();
    seq.push_back(state_o);
    n = 1;
    for (int i = 0; i < 50 && mmcm_rst; i++) begin
      tick(1, 0, 0);
      if (mmcm_rst) n++;
    end
    chk("t1_rst_pulse_len", n, 4);
    for (int i = 0; i < 6; i++) tick(1, 0, 0);
    run_until(3, 1, 100, "t1_reach_run");
    chk("t1_stable_to_run", t_run - t_stable, 8);
    chk("t1_seq_len", seq.size(), 4);
    chk("t1_seq", pack_seq(), 83);

    // Glitchy lock in STABLE
    tick(0, 1, 0); tick(0, 1, 0);
    run_until(2, 1, 50, "t2_reach_stable");
    for (int i = 0; i < 5; i++) tick(1, 1, 0);
    seq.delete();
    core_bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      if (core_rst_n) core_bad = 1;
    end
    for (int i = 0; i < 60 && state_o != 3'd3; i++) begin
      tick(1, 1, 0);
      if (core_rst_n && state_o != 3'd3) core_bad = 1;
    end
    chk("t2_reach_run", state_o, 3);
    chk("t2_seq", pack_seq(), 1107);
    chk("t2_window_restart", t_run - t_stable, 8);
    chk("t2_core_held", core_bad, 0);

    // Timeout and fault
    tick(0, 0, 0); tick(0, 0, 0);
    segs.delete();
    seglen = 1;
    for (int i = 0; i < 200 && state_o != 3'd4; i++) begin
      tick(1, 0, 0);
      if (mmcm_rst && state_o == 3'd0) seglen++;
      else if (seglen > 0) begin segs.push_back(seglen); seglen = 0; end
    end
    chk("t3_fault_state", state_o, 4);
    chk("t3_pulse_count", segs.size(), 3);
    foreach (segs[i]) chk("t3_pulse_len", segs[i], 4);
    for (int i = 0; i < 20; i++) tick(1, i[0], 0);
    chk("t3_fault_sticky", seq_fault, 1);
    tick(0, 0, 0);
    chk("t3_clr_fault", seq_fault, 0);
    chk("t3_clr_state", state_o, 0);

    // Lock loss in RUN
    tick(0, 1, 0);
    run_until(3, 1, 100, "t4_reach_run");
    tick(1, 0, 0);
    n = 1;
    for (int i = 0; i < 10 && core_rst_n; i++) begin
      tick(1, 0, 0);
      n++;
    end
    chk("t4_loss_latency", n, 3);
    chk("t4_loss_count", lock_loss_count, 1);
    run_until(3, 1, 100, "t4_rerun");

    // Soft requests
    tick(1, 1, 1);
    chk("t5_soft_run", state_o, 0);
    chk("t5_soft_count", lock_loss_count, 1);
    run_until(1, 0, 50, "t5_reach_wait");
    tick(1, 0, 1);
    chk("t5_soft_wait", state_o, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    chk("t5_soft_not_queued", state_o, 1);
    run_until(3, 1, 100, "t5_rerun");
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 1);
    chk("t5_both_state", state_o, 0);
    chk("t5_both_count", lock_loss_count, 2);

    // Saturation then mid-STABLE reset
    tick(0, 1, 0);
    for (int k = 0; k < 256; k++) begin
      run_until(3, 1, 100, "t6_run");
      tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    end
    chk("t6_saturate", lock_loss_count, 255);
    run_until(2, 1, 100, "t6_reach_stable");
    tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
    chk("t6_mid_stable", state_o, 2);
    tick(0, 1, 0);
    chk("t6_rst_state", state_o, 0);
    chk("t6_rst_mmcm", mmcm_rst, 1);
    chk("t6_rst_core", core_rst_n, 0);
    chk("t6_rst_fault", seq_fault, 0);
    chk("t6_rst_count", lock_loss_count, 0);

    // Randomized stress against the model
    lk = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 14) == 0) lk = ~lk;
      tick($urandom_range(0, 199) != 0, lk, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
